// File: rtl/fifo_wptr_full.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | fifo_wptr_full: write-side pointer, full/almost-full/level/overflow    |
// | logic for an async FIFO. Rev 1.0                                       |
// +------------------------------------------------------------------------+
module fifo_wptr_full #(
  parameter int ADDR_WIDTH   = 4,
  parameter int AFULL_THRESH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  winc,
  input  logic                  wovf_clr,
  input  logic [ADDR_WIDTH:0]   wq2_rptr,
  output logic                  wen,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [ADDR_WIDTH:0]   wptr,
  output logic                  wfull,
  output logic                  walmost_full,
  output logic [ADDR_WIDTH:0]   wlevel,
  output logic                  woverflow
);

  // Full when the write Gray pointer equals the read Gray pointer with its top two bits inverted
  localparam logic [ADDR_WIDTH:0] C_FULL_MASK = (ADDR_WIDTH+1)'(3 << (ADDR_WIDTH-1));
  localparam logic [ADDR_WIDTH:0] C_AFULL     = (ADDR_WIDTH+1)'(AFULL_THRESH);

  logic [ADDR_WIDTH:0] r_wbin;
  logic [ADDR_WIDTH:0] r_wptr;
  logic                r_wfull;
  logic                r_walmost_full;
  logic [ADDR_WIDTH:0] r_wlevel;
  logic                r_woverflow;

  logic                w_wen;
  logic [ADDR_WIDTH:0] w_wbin_next;
  logic [ADDR_WIDTH:0] w_wgray_next;
  logic [ADDR_WIDTH:0] w_rbin;
  logic [ADDR_WIDTH:0] w_wlevel_next;

  function automatic logic [ADDR_WIDTH:0] gray2bin(input logic [ADDR_WIDTH:0] g);
    logic [ADDR_WIDTH:0] b;
    b[ADDR_WIDTH] = g[ADDR_WIDTH];
    for (int i = ADDR_WIDTH - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  assign w_wen         = winc && !r_wfull && !rst;
  assign w_wbin_next   = r_wbin + {{ADDR_WIDTH{1'b0}}, w_wen};
  assign w_wgray_next  = (w_wbin_next >> 1) ^ w_wbin_next;
  assign w_rbin        = gray2bin(wq2_rptr);
  assign w_wlevel_next = w_wbin_next - w_rbin;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wbin         <= '0;
      r_wptr         <= '0;
      r_wfull        <= 1'b0;
      r_walmost_full <= 1'b0;
      r_wlevel       <= '0;
      r_woverflow    <= 1'b0;
    end else begin
      r_wbin         <= w_wbin_next;
      r_wptr         <= w_wgray_next;
      r_wfull        <= (w_wgray_next == (wq2_rptr ^ C_FULL_MASK));
      r_walmost_full <= (w_wlevel_next >= C_AFULL);
      r_wlevel       <= w_wlevel_next;
      // A new overflow event outranks a simultaneous clear
      if (winc && r_wfull) begin
        r_woverflow <= 1'b1;
      end else if (wovf_clr) begin
        r_woverflow <= 1'b0;
      end
    end
  end

  assign wen          = w_wen;
  assign waddr        = r_wbin[ADDR_WIDTH-1:0];
  assign wptr         = r_wptr;
  assign wfull        = r_wfull;
  assign walmost_full = r_walmost_full;
  assign wlevel       = r_wlevel;
  assign woverflow    = r_woverflow;

endmodule
`default_nettype wire

// File: tb/tb_fifo_wptr_full.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_fifo_wptr_full: scoreboard bench with a count-based reference model |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module tb_fifo_wptr_full;
  localparam int AW = 4;
  localparam int TH = 12;
  localparam int D  = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          winc;
  logic          wovf_clr;
  logic [AW:0]   wq2_rptr;
  logic          wen;
  logic [AW-1:0] waddr;
  logic [AW:0]   wptr;
  logic          wfull;
  logic          walmost_full;
  logic [AW:0]   wlevel;
  logic          woverflow;

  fifo_wptr_full #(.ADDR_WIDTH(AW), .AFULL_THRESH(TH)) dut (
    .clk(clk), .rst(rst), .winc(winc), .wovf_clr(wovf_clr), .wq2_rptr(wq2_rptr),
    .wen(wen), .waddr(waddr), .wptr(wptr), .wfull(wfull),
    .walmost_full(walmost_full), .wlevel(wlevel), .woverflow(woverflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int wen, waddr, wptr, wfull, wafull, wlevel, wovf;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  // Reference model: total accepted writes and reads as plain counts
  int m_w, m_r;
  int m_full, m_afull, m_level, m_ovf;

  function automatic logic [AW:0] gray(input int b);
    logic [AW:0] v;
    v = AW'(0) + (AW+1)'(b % (2 * D));
    return v ^ (v >> 1);
  endfunction

  task automatic chk(input string name, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp_v);
    end
  endtask

  task automatic model_reset();
    m_w = 0; m_r = 0; m_full = 0; m_afull = 0; m_level = 0; m_ovf = 0;
  endtask

  // One clock cycle: drive inputs, queue the expected outputs for this cycle, advance model
  task automatic step(input bit r, input bit wi, input bit clr, input bit ri);
    exp_t e;
    int   acc;
    rst = r; winc = wi; wovf_clr = clr;
    if (r) begin
      wq2_rptr = '0;
    end else begin
      if (ri && (m_r < m_w)) m_r++;
      wq2_rptr = gray(m_r);
    end
    acc = (wi && !m_full && !r) ? 1 : 0;
    e.wen = acc; e.waddr = m_w % D; e.wptr = int'(gray(m_w));
    e.wfull = m_full; e.wafull = m_afull; e.wlevel = m_level; e.wovf = m_ovf;
    q.push_back(e);
    if (r) begin
      model_reset();
    end else begin
      m_w     += acc;
      m_ovf    = (wi && m_full) ? 1 : (clr ? 0 : m_ovf);
      m_level  = m_w - m_r;
      m_full   = (m_level == D) ? 1 : 0;
      m_afull  = (m_level >= TH) ? 1 : 0;
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  // Monitor: compares every queued expectation against the DUT mid-cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("wen",          int'(wen),          e.wen);
        chk("waddr",        int'(waddr),        e.waddr);
        chk("wptr",         int'(wptr),         e.wptr);
        chk("wfull",        int'(wfull),        e.wfull);
        chk("walmost_full", int'(walmost_full), e.wafull);
        chk("wlevel",       int'(wlevel),       e.wlevel);
        chk("woverflow",    int'(woverflow),    e.wovf);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int wait_n;
    rst = 1'b1; winc = 1'b1; wovf_clr = 1'b0; wq2_rptr = '0;
    model_reset();
    @(posedge clk); #1;

    // Reset held with winc high
    repeat (2) step(1, 1, 0, 0);
    // Fill to full and one dropped push
    repeat (17) step(0, 1, 0, 0);
    // Release by one read, observe, refill with one write, observe
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    // Overflow priority: set+clear together, then clear alone
    step(0, 1, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);

    // Wrap: fill 16, read 16, write 16 so wbin goes 16 -> 0
    step(1, 0, 0, 0);
    repeat (16) step(0, 1, 0, 0);
    repeat (16) step(0, 0, 0, 1);
    repeat (16) step(0, 1, 0, 0);
    step(0, 0, 0, 0);

    // Mid-operation reset
    step(1, 0, 0, 0);
    repeat (5) step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    step(0, 0, 0, 0);

    // Randomized phases with varying write/read pressure
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 800; i++) begin
        step(($urandom_range(0, 199) == 0),
             ($urandom_range(0, 99) < 30 + 20 * p),
             ($urandom_range(0, 9) == 0),
             ($urandom_range(0, 99) < 70 - 15 * p));
      end
    end
    step(0, 0, 0, 0);

    wait_n = 0;
    while (q.size() > 0 && wait_n < 10) begin
      @(posedge clk); #1;
      wait_n++;
    end
    if (q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
